// File: rtl/itbm_arb.sv
// -----------------------------------------------------------------------------
// itbm_arb: two-requester arbiter and tag tracker in front of a shared LAT-cycle rotator.
// Rev 1.0 -- define ITBM_ARB_FIXED_PRIO_EN for strict requester-0 priority (default round-robin).
// -----------------------------------------------------------------------------
`default_nettype none

module itbm_arb #(
    parameter int LAT = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_clr,
    input  logic        i_req0_valid,
    input  logic [11:0] i_req0_x,
    input  logic [11:0] i_req0_y,
    input  logic [13:0] i_req0_z,
    input  logic        i_req1_valid,
    input  logic [11:0] i_req1_x,
    input  logic [11:0] i_req1_y,
    input  logic [13:0] i_req1_z,
    output logic        o_req0_ready,
    output logic        o_req1_ready,
    output logic        o_rot_start,
    output logic [11:0] o_rot_x,
    output logic [11:0] o_rot_y,
    output logic [13:0] o_rot_z,
    input  logic        i_rot_done,
    input  logic [11:0] i_rot_x,
    input  logic [11:0] i_rot_y,
    output logic        o_res0_valid,
    output logic [11:0] o_res0_x,
    output logic [11:0] o_res0_y,
    output logic        o_res1_valid,
    output logic [11:0] o_res1_x,
    output logic [11:0] o_res1_y,
    output logic [3:0]  o_inflight,
    output logic        o_err
);

    logic           grant0;
    logic           grant1;
    logic           issue_id;
    logic [LAT-1:0] tag_valid;
    logic [LAT-1:0] tag_live;
    logic [LAT-1:0] tag_id;
    logic           tail_valid;
    logic           tail_live;
    logic           tail_id;
    logic           hit;

`ifdef ITBM_ARB_FIXED_PRIO_EN
    always_comb begin
        grant0 = i_req0_valid & ~i_clr;
        grant1 = i_req1_valid & ~i_req0_valid & ~i_clr;
    end
`else
    logic last_id;  // requester granted most recently; reset to 1 so requester 0 wins first

    always_comb begin
        grant0 = i_req0_valid & ~i_clr & (~i_req1_valid | last_id);
        grant1 = i_req1_valid & ~i_clr & ~grant0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_id <= 1'b1;
        end else if (grant0 | grant1) begin
            last_id <= grant1;
        end
    end
`endif

    assign o_req0_ready = grant0;
    assign o_req1_ready = grant1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_rot_start <= 1'b0;
            o_rot_x     <= '0;
            o_rot_y     <= '0;
            o_rot_z     <= '0;
            issue_id    <= 1'b0;
        end else begin
            o_rot_start <= grant0 | grant1;
            if (grant0) begin
                o_rot_x  <= i_req0_x;
                o_rot_y  <= i_req0_y;
                o_rot_z  <= i_req0_z;
                issue_id <= 1'b0;
            end else if (grant1) begin
                o_rot_x  <= i_req1_x;
                o_rot_y  <= i_req1_y;
                o_rot_z  <= i_req1_z;
                issue_id <= 1'b1;
            end
        end
    end

    // The head is loaded from the issue register so the tail lines up with the rotator strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_valid <= '0;
            tag_live  <= '0;
            tag_id    <= '0;
        end else begin
            tag_valid[0] <= o_rot_start;
            tag_live[0]  <= o_rot_start & ~i_clr;
            tag_id[0]    <= issue_id;
            for (int k = 1; k < LAT; k++) begin
                tag_valid[k] <= tag_valid[k-1];
                tag_live[k]  <= tag_live[k-1] & ~i_clr;
                tag_id[k]    <= tag_id[k-1];
            end
        end
    end

    assign tail_valid = tag_valid[LAT-1];
    assign tail_live  = tag_live[LAT-1];
    assign tail_id    = tag_id[LAT-1];
    assign hit        = tail_live & i_rot_done & ~i_clr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_res0_valid <= 1'b0;
            o_res0_x     <= '0;
            o_res0_y     <= '0;
            o_res1_valid <= 1'b0;
            o_res1_x     <= '0;
            o_res1_y     <= '0;
        end else begin
            o_res0_valid <= hit & ~tail_id;
            o_res1_valid <= hit & tail_id;
            if (hit & ~tail_id) begin
                o_res0_x <= i_rot_x;
                o_res0_y <= i_rot_y;
            end
            if (hit & tail_id) begin
                o_res1_x <= i_rot_x;
                o_res1_y <= i_rot_y;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_inflight <= '0;
            o_err      <= 1'b0;
        end else begin
            case ({o_rot_start, tail_valid})
                2'b10:   o_inflight <= o_inflight + 4'd1;
                2'b01:   o_inflight <= o_inflight - 4'd1;
                default: o_inflight <= o_inflight;
            endcase
            if (i_rot_done != tail_valid) begin
                o_err <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_itbm_arb.sv
// -----------------------------------------------------------------------------
// tb_itbm_arb: directed + randomized bench for itbm_arb with an echoing rotator and a
// transaction-level reference model (accept cycle -> start, result, in-flight windows).
// -----------------------------------------------------------------------------
`default_nettype none

module tb_itbm_arb;

    localparam int LAT = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_clr;
    logic        i_req0_valid, i_req1_valid;
    logic [11:0] i_req0_x, i_req0_y, i_req1_x, i_req1_y;
    logic [13:0] i_req0_z, i_req1_z;
    logic        o_req0_ready, o_req1_ready;
    logic        o_rot_start;
    logic [11:0] o_rot_x, o_rot_y;
    logic [13:0] o_rot_z;
    logic        i_rot_done;
    logic [11:0] i_rot_x, i_rot_y;
    logic        o_res0_valid, o_res1_valid;
    logic [11:0] o_res0_x, o_res0_y, o_res1_x, o_res1_y;
    logic [3:0]  o_inflight;
    logic        o_err;
    logic        inj;

    always #5 clk = ~clk;

    itbm_arb #(.LAT(LAT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_clr        (i_clr),
        .i_req0_valid (i_req0_valid),
        .i_req0_x     (i_req0_x),
        .i_req0_y     (i_req0_y),
        .i_req0_z     (i_req0_z),
        .i_req1_valid (i_req1_valid),
        .i_req1_x     (i_req1_x),
        .i_req1_y     (i_req1_y),
        .i_req1_z     (i_req1_z),
        .o_req0_ready (o_req0_ready),
        .o_req1_ready (o_req1_ready),
        .o_rot_start  (o_rot_start),
        .o_rot_x      (o_rot_x),
        .o_rot_y      (o_rot_y),
        .o_rot_z      (o_rot_z),
        .i_rot_done   (i_rot_done),
        .i_rot_x      (i_rot_x),
        .i_rot_y      (i_rot_y),
        .o_res0_valid (o_res0_valid),
        .o_res0_x     (o_res0_x),
        .o_res0_y     (o_res0_y),
        .o_res1_valid (o_res1_valid),
        .o_res1_x     (o_res1_x),
        .o_res1_y     (o_res1_y),
        .o_inflight   (o_inflight),
        .o_err        (o_err)
    );

    // Rotator stand-in: echoes its operands LAT cycles after start; it has no reset.
    bit        rp_v [LAT];
    bit [11:0] rp_x [LAT];
    bit [11:0] rp_y [LAT];
    always @(posedge clk) begin
        rp_v[0] <= o_rot_start;
        rp_x[0] <= o_rot_x;
        rp_y[0] <= o_rot_y;
        for (int k = 1; k < LAT; k++) begin
            rp_v[k] <= rp_v[k-1];
            rp_x[k] <= rp_x[k-1];
            rp_y[k] <= rp_y[k-1];
        end
    end
    assign i_rot_done = rp_v[LAT-1] | inj;
    assign i_rot_x    = rp_x[LAT-1];
    assign i_rot_y    = rp_y[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int        t;      // accept cycle
        bit        id;
        bit [11:0] x;
        bit [11:0] y;
        bit [13:0] z;
        bit        live;
        bit        stale;  // started before a reset
    } op_t;

    op_t       ops[$];
    bit        pend [2];
    bit [11:0] px [2];
    bit [11:0] py [2];
    bit [13:0] pz [2];
    bit        last_m;
    bit        err_m, err_pend;
    bit [11:0] rx_m, ry_m;
    bit [13:0] rz_m;
    bit [11:0] resx_m [2];
    bit [11:0] resy_m [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic set_req(input int r, input bit [11:0] x, input bit [11:0] y, input bit [13:0] z);
        pend[r] = 1'b1;
        px[r] = x;
        py[r] = y;
        pz[r] = z;
    endtask

    task automatic check_outputs();
        bit exp_start;
        bit exp_v [2];
        int exp_inf;
        exp_start = 1'b0;
        exp_v = '{1'b0, 1'b0};
        exp_inf = 0;
        foreach (ops[k]) begin
            if (!ops[k].stale) begin
                if (ops[k].t == cyc - 1) begin
                    exp_start = 1'b1;
                    rx_m = ops[k].x;
                    ry_m = ops[k].y;
                    rz_m = ops[k].z;
                end
                if (ops[k].t + LAT + 2 == cyc && ops[k].live) begin
                    exp_v[ops[k].id] = 1'b1;
                    resx_m[ops[k].id] = ops[k].x;
                    resy_m[ops[k].id] = ops[k].y;
                end
                if (ops[k].t + 2 <= cyc && cyc <= ops[k].t + LAT + 1) exp_inf++;
            end
        end
        chk("rot_start", 32'(o_rot_start), 32'(exp_start));
        chk("rot_x", 32'(o_rot_x), 32'(rx_m));
        chk("rot_y", 32'(o_rot_y), 32'(ry_m));
        chk("rot_z", 32'(o_rot_z), 32'(rz_m));
        chk("res0_valid", 32'(o_res0_valid), 32'(exp_v[0]));
        chk("res1_valid", 32'(o_res1_valid), 32'(exp_v[1]));
        chk("res0_x", 32'(o_res0_x), 32'(resx_m[0]));
        chk("res0_y", 32'(o_res0_y), 32'(resy_m[0]));
        chk("res1_x", 32'(o_res1_x), 32'(resx_m[1]));
        chk("res1_y", 32'(o_res1_y), 32'(resy_m[1]));
        chk("inflight", 32'(o_inflight), 32'(exp_inf));
        chk("err", 32'(o_err), 32'(err_m));
        while (ops.size() > 0 && ops[0].t + LAT + 2 <= cyc) void'(ops.pop_front());
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic run_cycle(input int rate, input bit clr, input bit inj_in);
        bit  g0, g1, done_m, tail_m;
        op_t o;
        for (int r = 0; r < 2; r++) begin
            if (!pend[r]) begin
                if (rate > 0 && $urandom_range(0, 99) < rate)
                    set_req(r, 12'($urandom), 12'($urandom), 14'($urandom));
            end else if (rate > 0 && rate < 100 && $urandom_range(0, 9) == 0) begin
                pend[r] = 1'b0;
            end
        end
        i_req0_valid = pend[0]; i_req0_x = px[0]; i_req0_y = py[0]; i_req0_z = pz[0];
        i_req1_valid = pend[1]; i_req1_x = px[1]; i_req1_y = py[1]; i_req1_z = pz[1];
        i_clr = clr;
        inj   = inj_in;
        #1;
        check_outputs();
`ifdef ITBM_ARB_FIXED_PRIO_EN
        g0 = pend[0] && !clr;
        g1 = pend[1] && !clr && !pend[0];
`else
        g0 = pend[0] && !clr && (!pend[1] || last_m);
        g1 = pend[1] && !clr && !g0;
`endif
        chk("ready0", 32'(o_req0_ready), 32'(g0));
        chk("ready1", 32'(o_req1_ready), 32'(g1));
        if (clr) begin
            foreach (ops[k])
                if (ops[k].t + 1 <= cyc && cyc <= ops[k].t + LAT + 1) ops[k].live = 1'b0;
        end
        done_m = inj_in;
        tail_m = 1'b0;
        foreach (ops[k]) begin
            if (ops[k].t + LAT + 1 == cyc) begin
                done_m = 1'b1;
                if (!ops[k].stale) tail_m = 1'b1;
            end
        end
        if (done_m != tail_m) err_pend = 1'b1;
        if (g0 || g1) begin
            o.t = cyc; o.id = g1; o.x = px[g1]; o.y = py[g1]; o.z = pz[g1];
            o.live = 1'b1; o.stale = 1'b0;
            ops.push_back(o);
            last_m = g1;
            pend[g1] = 1'b0;
        end
        @(negedge clk);
        err_m = err_m | err_pend;
        err_pend = 1'b0;
    endtask

    task automatic idle(input int n);
        pend = '{1'b0, 1'b0};
        repeat (n) run_cycle(0, 1'b0, 1'b0);
    endtask

    // Entered at a falling edge; returns at the falling edge where reset is released.
    task automatic do_reset(input int n);
        reset_n = 1'b0;
        i_clr = 1'b0; inj = 1'b0;
        i_req0_valid = 1'b0; i_req1_valid = 1'b0;
        pend = '{1'b0, 1'b0};
        foreach (ops[k]) ops[k].stale = 1'b1;
        last_m = 1'b1; err_m = 1'b0; err_pend = 1'b0;
        rx_m = '0; ry_m = '0; rz_m = '0;
        resx_m = '{12'h0, 12'h0}; resy_m = '{12'h0, 12'h0};
        #1;
        chk("rst_rot_start", 32'(o_rot_start), 32'd0);
        chk("rst_rot_x", 32'(o_rot_x), 32'd0);
        chk("rst_res0_valid", 32'(o_res0_valid), 32'd0);
        chk("rst_res1_valid", 32'(o_res1_valid), 32'd0);
        chk("rst_res1_x", 32'(o_res1_x), 32'd0);
        chk("rst_inflight", 32'(o_inflight), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        repeat (n) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        inj = 1'b0;
        i_clr = 1'b0;
        i_req0_valid = 1'b0; i_req1_valid = 1'b0;
        i_req0_x = '0; i_req0_y = '0; i_req0_z = '0;
        i_req1_x = '0; i_req1_y = '0; i_req1_z = '0;
        @(negedge clk);
        do_reset(3);

        // single requester-0 operation with known operands
        idle(2);
        set_req(0, 12'h100, 12'h000, 14'h0000);
        run_cycle(0, 1'b0, 1'b0);
        idle(LAT + 4);

        // both requesters valid for six cycles: alternating grants
        set_req(0, 12'($urandom), 12'($urandom), 14'($urandom));
        set_req(1, 12'($urandom), 12'($urandom), 14'($urandom));
        repeat (6) run_cycle(100, 1'b0, 1'b0);
        idle(LAT + 4);

        // three issues then a one-cycle flush: no results, no error
        set_req(0, 12'($urandom), 12'($urandom), 14'($urandom));
        run_cycle(0, 1'b0, 1'b0);
        set_req(1, 12'($urandom), 12'($urandom), 14'($urandom));
        run_cycle(0, 1'b0, 1'b0);
        set_req(0, 12'($urandom), 12'($urandom), 14'($urandom));
        run_cycle(0, 1'b0, 1'b0);
        idle(1);
        run_cycle(0, 1'b1, 1'b0);
        idle(LAT + 4);

        // spurious strobe on an empty tag pipeline: sticky error until reset
        run_cycle(0, 1'b0, 1'b1);
        idle(4);
        do_reset(2);
        idle(2);

        // randomized traffic with occasional flushes
        for (int i = 0; i < 300; i++)
            run_cycle(50, ($urandom_range(0, 99) < 3), 1'b0);
        idle(LAT + 4);

        // reset with operations still inside the rotator: their strobes flag an error
        repeat (5) run_cycle(70, 1'b0, 1'b0);
        idle(2);
        do_reset(2);
        idle(LAT + 4);
        do_reset(2);

        for (int i = 0; i < 200; i++)
            run_cycle(60, ($urandom_range(0, 99) < 2), 1'b0);
        idle(LAT + 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
